// File: rtl/shift_pattern_ctrl.sv
// rtl/shift_pattern_ctrl.sv - button front end, run-mode FSM, speed level and step/load strobes
// for the 8-position running-light datapath.
module shift_pattern_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_BASE       = 80_000_000,
  parameter int unsigned REPEAT_CYCLES   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnc,
  input  logic       btnd,
  input  logic       btnl,
  input  logic       btnr,
  input  logic       btnu,
  output logic [1:0] dir,
  output logic [2:0] speed_lvl,
  output logic       load,
  output logic [7:0] load_val,
  output logic       step
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  localparam int B_C = 0;
  localparam int B_D = 1;
  localparam int B_U = 2;
  localparam int B_L = 3;
  localparam int B_R = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_L = 2'd1,
    ST_RUN_R = 2'd2
  } state_t;

  logic [4:0]      w_btn;
  logic [4:0]      r_sync1;
  logic [4:0]      r_sync2;
  logic [4:0]      r_deb;
  logic [4:0]      r_deb_q;
  logic [4:0]      r_evt;
  logic [DB_W-1:0] r_db_cnt [5];
  logic [RP_W-1:0] r_rep_cnt [2];
  logic [4:0]      w_rise;
  logic [1:0]      w_rep;

  assign w_btn  = {btnr, btnl, btnu, btnd, btnc};
  assign w_rise = r_deb & ~r_deb_q;

  // Auto-repeat lanes: index 0 is D, index 1 is U.
  always_comb begin
    w_rep = '0;
    for (int j = 0; j < 2; j++) begin
      w_rep[j] = r_deb[j+1] & ~w_rise[j+1] & (r_rep_cnt[j] == RP_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      r_evt   <= '0;
      for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
      for (int j = 0; j < 2; j++) r_rep_cnt[j] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= ~r_deb[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
      for (int j = 0; j < 2; j++) begin
        if (!r_deb[j+1] || w_rise[j+1] || (r_rep_cnt[j] == RP_LAST)) begin
          r_rep_cnt[j] <= '0;
        end else begin
          r_rep_cnt[j] <= r_rep_cnt[j] + 1'b1;
        end
      end
      r_evt <= w_rise | {2'b00, w_rep[1], w_rep[0], 1'b0};
    end
  end

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_speed;
  logic [2:0]  w_speed_next;
  logic        r_load;
  logic        w_load_next;
  logic [7:0]  r_load_val;
  logic [7:0]  w_load_val_next;
  logic        r_step;
  logic        w_step_next;
  logic [31:0] r_acc;
  logic [31:0] w_acc_next;
  logic [31:0] w_inc;
  logic [31:0] w_acc_sum;

  assign w_inc     = 32'd1 << r_speed;
  assign w_acc_sum = r_acc + w_inc;

  always_comb begin
    w_state_next    = r_state;
    w_speed_next    = r_speed;
    w_load_next     = 1'b0;
    w_load_val_next = r_load_val;
    w_step_next     = 1'b0;
    w_acc_next      = r_acc;

    if (r_evt[B_C]) begin
      w_state_next    = ST_IDLE;
      w_load_next     = 1'b1;
      w_load_val_next = 8'h00;
    end else if (r_evt[B_D]) begin
      if (r_speed != 3'd0) w_speed_next = r_speed - 3'd1;
    end else if (r_evt[B_U]) begin
      if (r_speed != 3'd6) w_speed_next = r_speed + 3'd1;
    end else if (r_evt[B_L]) begin
      w_state_next    = ST_RUN_L;
      w_load_next     = 1'b1;
      w_load_val_next = 8'h01;
    end else if (r_evt[B_R]) begin
      w_state_next    = ST_RUN_R;
      w_load_next     = 1'b1;
      w_load_val_next = 8'h80;
    end

    // A load restarts the step period from zero; speed commands keep accumulating.
    if (w_load_next || (r_state == ST_IDLE)) begin
      w_acc_next = '0;
    end else if (w_acc_sum >= TICK_BASE) begin
      w_acc_next  = '0;
      w_step_next = 1'b1;
    end else begin
      w_acc_next = w_acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_speed    <= 3'd3;
      r_load     <= 1'b0;
      r_load_val <= 8'h00;
      r_step     <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_speed    <= w_speed_next;
      r_load     <= w_load_next;
      r_load_val <= w_load_val_next;
      r_step     <= w_step_next;
      r_acc      <= w_acc_next;
    end
  end

  assign dir       = r_state;
  assign speed_lvl = r_speed;
  assign load      = r_load;
  assign load_val  = r_load_val;
  assign step      = r_step;

endmodule

// File: tb/tb_shift_pattern_ctrl.sv
// tb/tb_shift_pattern_ctrl.sv - directed bench for shift_pattern_ctrl with short timing parameters.
module tb_shift_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btnc, btnd, btnl, btnr, btnu;
  logic [1:0] dir;
  logic [2:0] speed_lvl;
  logic       load;
  logic [7:0] load_val;
  logic       step;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_pattern_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_BASE(64),
    .REPEAT_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btnc(btnc),
    .btnd(btnd),
    .btnl(btnl),
    .btnr(btnr),
    .btnu(btnu),
    .dir(dir),
    .speed_lvl(speed_lvl),
    .load(load),
    .load_val(load_val),
    .step(step)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {btnc, btnd, btnl, btnr, btnu} = '0;
    tick();
    rst_n = 1'b1;
    checks++; if (dir !== 2'd0) begin $display("FAIL reset_dir got=%0d exp=0", dir); errors++; end
    checks++; if (speed_lvl !== 3'd3) begin $display("FAIL reset_speed got=%0d exp=3", speed_lvl); errors++; end
    checks++; if (load !== 1'b0) begin $display("FAIL reset_load got=%b exp=0", load); errors++; end
    checks++; if (load_val !== 8'h00) begin $display("FAIL reset_load_val got=%h exp=00", load_val); errors++; end
    checks++; if (step !== 1'b0) begin $display("FAIL reset_step got=%b exp=0", step); errors++; end
    ticks(3);
  endtask

  task automatic test_left();
    logic exp_load, exp_step;
    btnl = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (k == 20) btnl = 1'b0;
      exp_load = (k == 8);
      exp_step = (k > 8) && ((k - 8) % 8 == 0);
      checks++; if (load !== exp_load) begin $display("FAIL left_load k=%0d got=%b exp=%b", k, load, exp_load); errors++; end
      checks++; if (step !== exp_step) begin $display("FAIL left_step k=%0d got=%b exp=%b", k, step, exp_step); errors++; end
      if (k == 8) begin
        checks++; if (load_val !== 8'h01) begin $display("FAIL left_load_val got=%h exp=01", load_val); errors++; end
        checks++; if (dir !== 2'd1) begin $display("FAIL left_dir got=%0d exp=1", dir); errors++; end
      end
    end
  endtask

  task automatic test_glitch_then_right();
    btnr = 1'b1;
    ticks(3);
    btnr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (load !== 1'b0) begin $display("FAIL glitch_load k=%0d got=%b exp=0", k, load); errors++; end
      checks++; if (dir !== 2'd1) begin $display("FAIL glitch_dir k=%0d got=%0d exp=1", k, dir); errors++; end
    end
    btnr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 10) btnr = 1'b0;
      checks++; if (load !== (k == 8)) begin $display("FAIL right_load k=%0d got=%b exp=%b", k, load, (k == 8)); errors++; end
      if (k == 7) begin
        checks++; if (dir !== 2'd1) begin $display("FAIL right_dir_before got=%0d exp=1", dir); errors++; end
      end
      if (k == 8) begin
        checks++; if (load_val !== 8'h80) begin $display("FAIL right_load_val got=%h exp=80", load_val); errors++; end
        checks++; if (dir !== 2'd2) begin $display("FAIL right_dir got=%0d exp=2", dir); errors++; end
      end
    end
    ticks(10);
  endtask

  task automatic test_speed_up();
    logic [2:0] exp_spd;
    btnu = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      tick();
      exp_spd = (k < 8) ? 3'd3 : (k < 40) ? 3'd4 : (k < 72) ? 3'd5 : 3'd6;
      checks++; if (speed_lvl !== exp_spd) begin $display("FAIL up_speed k=%0d got=%0d exp=%0d", k, speed_lvl, exp_spd); errors++; end
      checks++; if (dir !== 2'd2) begin $display("FAIL up_dir k=%0d got=%0d exp=2", k, dir); errors++; end
      checks++; if (load !== 1'b0) begin $display("FAIL up_load k=%0d got=%b exp=0", k, load); errors++; end
      if (k >= 73) begin
        checks++; if (step !== 1'b1) begin $display("FAIL up_step k=%0d got=%b exp=1", k, step); errors++; end
      end
    end
    btnu = 1'b0;
    ticks(10);
  endtask

  task automatic test_speed_down();
    int lvl;
    logic exp_step;
    btnd = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      lvl = (k < 8) ? 6 : 5 - (k - 8) / 32;
      if (lvl < 0) lvl = 0;
      checks++; if (speed_lvl !== 3'(lvl)) begin $display("FAIL down_speed k=%0d got=%0d exp=%0d", k, speed_lvl, lvl); errors++; end
      checks++; if (dir !== 2'd2) begin $display("FAIL down_dir k=%0d got=%0d exp=2", k, dir); errors++; end
    end
    btnd = 1'b0;
    ticks(10);
    btnr = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (k == 10) btnr = 1'b0;
      checks++; if (load !== (k == 8)) begin $display("FAIL slow_load k=%0d got=%b exp=%b", k, load, (k == 8)); errors++; end
      if (k == 8) begin
        checks++; if (load_val !== 8'h80) begin $display("FAIL slow_load_val got=%h exp=80", load_val); errors++; end
      end
      if (k > 8) begin
        exp_step = (k == 72) || (k == 136);
        checks++; if (step !== exp_step) begin $display("FAIL slow_step k=%0d got=%b exp=%b", k, step, exp_step); errors++; end
      end
    end
  endtask

  task automatic test_priority_cl();
    btnc = 1'b1;
    btnl = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (k == 10) begin btnc = 1'b0; btnl = 1'b0; end
      checks++; if (load !== (k == 8)) begin $display("FAIL cl_load k=%0d got=%b exp=%b", k, load, (k == 8)); errors++; end
      if (k == 8) begin
        checks++; if (load_val !== 8'h00) begin $display("FAIL cl_load_val got=%h exp=00", load_val); errors++; end
      end
      if (k >= 8) begin
        checks++; if (dir !== 2'd0) begin $display("FAIL cl_dir k=%0d got=%0d exp=0", k, dir); errors++; end
        checks++; if (step !== 1'b0) begin $display("FAIL cl_step k=%0d got=%b exp=0", k, step); errors++; end
      end
    end
  endtask

  task automatic test_priority_ul();
    logic [2:0] exp_spd;
    btnu = 1'b1;
    btnl = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 10) begin btnu = 1'b0; btnl = 1'b0; end
      exp_spd = (k < 8) ? 3'd0 : 3'd1;
      checks++; if (speed_lvl !== exp_spd) begin $display("FAIL ul_speed k=%0d got=%0d exp=%0d", k, speed_lvl, exp_spd); errors++; end
      checks++; if (load !== 1'b0) begin $display("FAIL ul_load k=%0d got=%b exp=0", k, load); errors++; end
      checks++; if (dir !== 2'd0) begin $display("FAIL ul_dir k=%0d got=%0d exp=0", k, dir); errors++; end
      checks++; if (step !== 1'b0) begin $display("FAIL ul_step k=%0d got=%b exp=0", k, step); errors++; end
    end
  endtask

  task automatic test_reset_mid();
    btnl = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 10) btnl = 1'b0;
      if (k == 8) begin
        checks++; if (load !== 1'b1) begin $display("FAIL mid_pre_load got=%b exp=1", load); errors++; end
        checks++; if (dir !== 2'd1) begin $display("FAIL mid_pre_dir got=%0d exp=1", dir); errors++; end
      end
    end
    btnd = 1'b1;
    ticks(4);
    rst_n = 1'b0;
    btnd  = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (dir !== 2'd0) begin $display("FAIL mid_dir got=%0d exp=0", dir); errors++; end
    checks++; if (speed_lvl !== 3'd3) begin $display("FAIL mid_speed got=%0d exp=3", speed_lvl); errors++; end
    checks++; if (load !== 1'b0) begin $display("FAIL mid_load got=%b exp=0", load); errors++; end
    checks++; if (load_val !== 8'h00) begin $display("FAIL mid_load_val got=%h exp=00", load_val); errors++; end
    checks++; if (step !== 1'b0) begin $display("FAIL mid_step got=%b exp=0", step); errors++; end
    for (int k = 1; k <= 80; k++) begin
      tick();
      checks++; if (load !== 1'b0) begin $display("FAIL post_load k=%0d got=%b exp=0", k, load); errors++; end
      checks++; if (step !== 1'b0) begin $display("FAIL post_step k=%0d got=%b exp=0", k, step); errors++; end
      checks++; if (speed_lvl !== 3'd3) begin $display("FAIL post_speed k=%0d got=%0d exp=3", k, speed_lvl); errors++; end
      checks++; if (dir !== 2'd0) begin $display("FAIL post_dir k=%0d got=%0d exp=0", k, dir); errors++; end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {btnc, btnd, btnl, btnr, btnu} = '0;
    #1;
    test_reset();
    test_left();
    test_glitch_then_right();
    test_speed_up();
    test_speed_down();
    test_priority_cl();
    test_priority_ul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_pattern_ctrl.md
# shift_pattern_ctrl

Command sequencer for the 8-position running-light datapath on the NEXYS4 board. It takes the five raw push-buttons, then synchronizes, debounces and edge-detects them. It runs the run-mode state machine and the speed level, and generates the load and step strobes that drive the 8-bit shift register feeding the 7-segment scan logic. It owns all timing decisions; the datapath only loads and shifts on command.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a button level is accepted
- TICK_BASE, 80_000_000, accumulator terminal value; step period = ceil(TICK_BASE / 2^speed_lvl) cycles
- REPEAT_CYCLES, 50_000_000, auto-repeat interval for held btnu/btnd
- clk  input  1  board clock (100 MHz)
- rst_n  input  1  reset, synchronous, active-low
- btnc, btnd, btnl, btnr, btnu  input  1 each  raw asynchronous buttons, active-high
- dir  output  2  0 = idle, 1 = rotate left, 2 = rotate right; 3 never driven
- speed_lvl  output  3  speed level 0..6; increment = 2^speed_lvl
- load  output  1  one-cycle strobe: datapath loads load_val
- load_val  output  8  pattern to load, valid when load = 1
- step  output  1  one-cycle strobe: datapath rotates one position in direction dir

## Operation
- Each button passes through a 2-flop synchronizer, then a per-button debouncer.
- Debouncer behaviour: when the synchronized level differs from the debounced state for DEBOUNCE_CYCLES consecutive cycles, the debounced state flips. Any return to the debounced level clears the count.
- A rising edge of a debounced state produces a one-cycle press event. Falling edges produce nothing.
- One command is executed per cycle. Priority among press events in the same cycle: C > D > U > L > R. Lower-priority events in that cycle are discarded, not queued.
- FSM states and commands:
  - IDLE, RUN_L, RUN_R; reset state is IDLE.
  - C, from any state: go to IDLE; load=1, load_val=0x00.
  - L, from any state (including RUN_L): go to RUN_L; load=1, load_val=0x01.
  - R, from any state (including RUN_R): go to RUN_R; load=1, load_val=0x80.
  - dir = 0/1/2 for IDLE/RUN_L/RUN_R.
- Speed:
  - U press: speed_lvl+1, saturating at 6.
  - D press: speed_lvl−1, saturating at 0.
  - While the debounced U (or D) stays high, it reapplies every REPEAT_CYCLES cycles, counted from the press event. Release clears the repeat counter.
  - A saturated request is a no-op with no error.
  - Speed changes never alter the state or the accumulator value.
- Tick accumulator (32-bit unsigned):
  - In RUN_L/RUN_R each cycle, next = acc + 2^speed_lvl.
  - If next ≥ TICK_BASE: acc ← 0 and step = 1; else acc ← next.
  - In IDLE, and in any cycle with load = 1, acc ← 0 and step = 0.
- step and load are never asserted in the same cycle.

## Timing
- Reset values, on the first rising edge with rst_n = 0: dir=0, speed_lvl=3, load=0, load_val=0x00, step=0, acc=0, all debounced states 0, all debounce and repeat counters 0, synchronizer flops 0.
- Reset mid-run takes effect on that edge. Any in-progress debounce or repeat is abandoned.
- Button-to-strobe latency is fixed at DEBOUNCE_CYCLES + 4 cycles, measured from the first edge sampling the new level to the edge at which load (or the speed_lvl change) is visible. This comprises 2 sync + DEBOUNCE_CYCLES + 1 edge detect + 1 registered output.
- All outputs are registered; there are no combinational paths from inputs.
- First step after a load occurs ceil(TICK_BASE / 2^speed_lvl) cycles after the load cycle; steps then repeat at that period.
- A press held indefinitely generates exactly one event, except for auto-repeat on U/D.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TICK_BASE=64, REPEAT_CYCLES=32.
- Reset, then btnl high for 20 cycles -> load=1 with load_val=0x01 exactly 8 cycles after the rise, and dir=1. step then pulses every 8 cycles (level 3, increment 8). After release: no further load.
- btnr glitch high for 3 cycles -> no load and dir unchanged. Then btnr high for 10 cycles -> load_val=0x80, dir=2.
- While running, btnu held 120 cycles -> speed_lvl 3→4 at latency 8, then 5 and 6 at +32-cycle intervals, then holds at 6 with step every cycle. btnd held similarly down to 0 -> step period 64.
- btnc and btnl rising in the same cycle while in RUN_R -> IDLE, load_val=0x00, dir=0, no step afterward. btnu and btnl simultaneous -> only the speed change; L is discarded.
- rst_n low for 1 cycle mid-run, with acc nonzero and btnd mid-debounce -> next edge gives all reset values. No step or load until a new debounced press.
